// File: rtl/mem_stall_ctrl_pkg.sv
// Shared pipeline definitions for the data-memory stall controller.
// Holds the controller state encoding and the pipeline NOP control word.
package mem_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StBusy  = 2'b01,
      StDone  = 2'b10,
      StFault = 2'b11
   } memState_e;

   // Control word the MEM/WB register emits while frozen.
   localparam logic [15:0] NopCtrlWord = 16'b0000100001000000;

   localparam logic [15:0] StallCntMax = 16'hFFFF;

endpackage

// File: rtl/mem_stall_ctrl_sat_counter16.sv
// 16-bit up-counter that sticks at its maximum value instead of wrapping.
module sat_counter16
   import mem_stall_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] countQ, countD;

   always_comb begin
      countD = countQ;
      if (inc && (countQ != StallCntMax)) begin
         countD = countQ + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         countQ <= 16'd0;
      end else begin
         countQ <= countD;
      end
   end

   assign count = countQ;

endmodule

// File: rtl/mem_stall_ctrl.sv
// Data-memory access controller: issues one command per accepted request and stalls
// the MEM/WB stage until completion, flagging misaligned accesses and memory timeouts.
module mem_stall_ctrl
   import mem_stall_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        mem_done,
   input  logic [15:0] mem_rdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        dmem_stall,
   output logic [15:0] rdata,
   output logic        err,
   output logic [15:0] stall_cnt
);

   localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

   memState_e   stateQ, stateD;
   logic [3:0]  waitQ, waitD, waitInc;
   logic        memEnQ, memEnD;
   logic        memWrQ, memWrD;
   logic [15:0] memAddrQ, memAddrD;
   logic [15:0] memWdataQ, memWdataD;
   logic [15:0] rdataQ, rdataD;

   // waitInc counts the current BUSY cycle, so FAULT follows exactly TIMEOUT idle BUSY cycles.
   assign waitInc = waitQ + 4'd1;

   always_comb begin
      stateD     = stateQ;
      waitD      = waitQ;
      memEnD     = 1'b0;
      memWrD     = memWrQ;
      memAddrD   = memAddrQ;
      memWdataD  = memWdataQ;
      rdataD     = rdataQ;
      dmem_stall = 1'b0;
      err        = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (req) begin
               if (addr[0]) begin
                  err = 1'b1;
               end else begin
                  dmem_stall = 1'b1;
                  memEnD     = 1'b1;
                  memWrD     = wr;
                  memAddrD   = addr;
                  memWdataD  = wdata;
                  waitD      = 4'd0;
                  stateD     = StBusy;
               end
            end
         end
         StBusy: begin
            dmem_stall = 1'b1;
            if (mem_done) begin
               if (!memWrQ) begin
                  rdataD = mem_rdata;
               end
               stateD = StDone;
            end else if (waitInc == TimeoutCnt) begin
               stateD = StFault;
            end else begin
               waitD = waitInc;
            end
         end
         StDone: begin
            stateD = StIdle;
         end
         StFault: begin
            err = 1'b1;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= StIdle;
         waitQ     <= 4'd0;
         memEnQ    <= 1'b0;
         memWrQ    <= 1'b0;
         memAddrQ  <= 16'd0;
         memWdataQ <= 16'd0;
         rdataQ    <= 16'd0;
      end else begin
         stateQ    <= stateD;
         waitQ     <= waitD;
         memEnQ    <= memEnD;
         memWrQ    <= memWrD;
         memAddrQ  <= memAddrD;
         memWdataQ <= memWdataD;
         rdataQ    <= rdataD;
      end
   end

   assign mem_en    = memEnQ;
   assign mem_wr    = memWrQ;
   assign mem_addr  = memAddrQ;
   assign mem_wdata = memWdataQ;
   assign rdata     = rdataQ;

   sat_counter16 uStallCnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (dmem_stall),
      .count (stall_cnt)
   );

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles in BUSY waiting for mem_done before the block declares a fault.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-004 req  in  1  EX/MEM stage requests a data-memory access this cycle.
REQ-005 wr  in  1  1 = store, 0 = load; qualified by req.
REQ-006 addr  in  16  byte address from EX/MEM.
REQ-007 wdata  in  16  store data from EX/MEM.
REQ-008 mem_done  in  1  memory completion strobe, valid only in BUSY.
REQ-009 mem_rdata  in  16  memory load data, valid with mem_done.
REQ-010 mem_en  out  1  one-cycle access strobe to memory.
REQ-011 mem_wr, mem_addr[15:0], mem_wdata[15:0]  out  registered command to memory.
REQ-012 dmem_stall  out  1  freezes the MEM/WB pipeline register and forces a NOP out of it.
REQ-013 rdata  out  16  load result presented to MEM/WB.
REQ-014 err  out  1  misaligned-access or timeout fault indication.
REQ-015 stall_cnt  out  16  saturating count of cycles with dmem_stall=1.

Function
REQ-016 FSM states: IDLE, BUSY, DONE, FAULT; 2-bit encoding.
REQ-017 IDLE, req=1, addr[0]=0: latch wr/addr/wdata into mem_* registers, pulse mem_en=1 in the first BUSY cycle only, go BUSY; dmem_stall=1 combinationally in this IDLE cycle.
REQ-018 IDLE, req=1, addr[0]=1: no memory command, err=1 for that cycle, dmem_stall=0, remain IDLE.
REQ-019 IDLE, req=0: dmem_stall=0, err=0, mem_en=0.
REQ-020 BUSY: dmem_stall=1 every cycle; mem_* command held stable.
REQ-021 BUSY, mem_done=1: capture mem_rdata into rdata (loads only; stores leave rdata unchanged), go DONE.
REQ-022 BUSY without mem_done: 4-bit wait counter increments; when the counter equals TIMEOUT and mem_done=0, go FAULT.
REQ-023 DONE: dmem_stall=0 for exactly one cycle so the pipeline advances; next state IDLE regardless of req.
REQ-024 Access latency: req-accepted to DONE = 1 + N cycles, where N = BUSY cycles up to and including mem_done; minimum 2.
REQ-025 mem_done outside BUSY is ignored.
REQ-026 FAULT: sticky until reset; err=1, dmem_stall=0, mem_en=0; req ignored.
REQ-027 stall_cnt increments on every cycle with dmem_stall=1 and saturates at 16'hFFFF.
REQ-028 rdata holds its last captured value in all states other than the BUSY-to-DONE edge.

Reset
REQ-029 rst=0 forces, asynchronously: state IDLE, wait counter 0, mem_en 0, mem_wr 0, mem_addr 0, mem_wdata 0, rdata 0, stall_cnt 0; combinational outputs then read dmem_stall=0, err=0.
REQ-030 Reset asserted mid-access (BUSY or DONE) abandons the access; a late mem_done after reset release is ignored per REQ-025.

Structure
REQ-031 State encodings and the NOP control word 16'b0000100001000000 reside in the shared pipeline package.
REQ-032 The saturating stall counter is a separate sub-module, sat_counter16.
REQ-033 All state uses the existing register cell convention; no latches; outputs dmem_stall and err are combinational from state and inputs only.

Verification
REQ-034 Load at addr 16'h0010, mem_done in the 3rd BUSY cycle with rdata 16'hBEEF -> mem_en pulses once, dmem_stall high for 4 cycles, rdata=16'hBEEF in DONE, stall_cnt=4.
REQ-035 Store at addr 16'h0020, wdata 16'h1234, mem_done in the 1st BUSY cycle -> mem_wr=1, mem_wdata=16'h1234, 2-cycle stall, rdata unchanged.
REQ-036 req with addr 16'h0011 -> err=1 for one cycle, mem_en never asserted, dmem_stall=0.
REQ-037 Load with mem_done never asserted -> FAULT after TIMEOUT BUSY cycles; err stays 1 and dmem_stall stays 0 until rst=0.
REQ-038 rst driven low during the 2nd BUSY cycle -> all outputs return to reset values immediately; a subsequent mem_done changes nothing.
REQ-039 Back-to-back loads with req held high -> exactly one DONE cycle between accesses; stall_cnt saturates at 16'hFFFF under forced long stalls.
